fetch_queue: RTL and testbench

Instruction buffer between the fetch stage (PC register plus instruction memory) and the decode stage. Captures each fetched {pc, instr} pair and presents it to decode in order with a valid/ready handshake. Drives the fetch enable as backpressure. Discards all buffered instructions on a branch/jump redirect.

---
 rtl/fetch_queue_pkg.sv | 23 ++
 rtl/fetch_queue_if.sv | 36 +++
 rtl/fetch_queue_mem.sv | 32 +++
 rtl/fetch_queue.sv | 89 ++++++++
 tb/tb_fetch_queue.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// fetch_queue_pkg : constants and the entry type shared by the fetch path
// Rev 1.0
// ============================================================================
package fetch_queue_pkg;

    // Must match the fetch stage's PC reset value
    localparam logic [31:0] RESET_PC    = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [31:0] LINK_OFFSET = 32'd8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] link_addr(input logic [31:0] pc);
        return pc + LINK_OFFSET;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// fetch_queue_if : fetch-side, decode-side and redirect signals of the queue
// Rev 1.0
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic [31:0]      out_link;
    logic             out_ready;
    logic             flush;
    logic [CNT_W-1:0] count;

    // Fetch/decode side
    modport master (
        output in_valid, in_pc, in_instr, out_ready, flush,
        input  in_ready, out_valid, out_pc, out_instr, out_link, count
    );

    // Queue side
    modport slave (
        input  in_valid, in_pc, in_instr, out_ready, flush,
        output in_ready, out_valid, out_pc, out_instr, out_link, count
    );

endinterface
`default_nettype wire

// File: rtl/fetch_queue_mem.sv
`default_nettype none
// ============================================================================
// fetch_queue_mem : DEPTH x 64 entry storage, one write port, one async read
// Rev 1.0
// ============================================================================
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  wire logic               clk,
    input  wire logic               i_we,
    input  wire logic [PTR_W-1:0]   i_waddr,
    input  wire fetch_entry_t       i_wdata,
    input  wire logic [PTR_W-1:0]   i_raddr,
    output fetch_entry_t            o_rdata
);

    // Contents are never cleared; validity is tracked by the pointers
    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : in-order {pc, instr} buffer between fetch and decode
// Rev 1.0
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = fetch_queue_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = fetch_queue_pkg::NOP_INSTR
) (
    input  wire logic       clk,
    input  wire logic       reset,
    fetch_queue_if.slave    bus
);

    localparam int              PTR_W  = $clog2(DEPTH);
    localparam int              CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    fetch_entry_t     w_wdata;
    fetch_entry_t     w_head;
    logic [31:0]      w_out_pc;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == C_FULL);

    // in_ready depends on count only, so decode never reaches fetch combinationally
    assign w_push  = bus.in_valid & ~w_full & ~bus.flush;
    assign w_pop   = ~w_empty & bus.out_ready;

    assign w_wdata.pc    = bus.in_pc;
    assign w_wdata.instr = bus.in_instr;

    fetch_queue_mem #(
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // A same-cycle pop on flush is still a valid handshake (delay slot)
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_out_pc      = w_empty ? RESET_PC : w_head.pc;

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = ~w_empty;
    assign bus.out_pc    = w_out_pc;
    assign bus.out_instr = w_empty ? NOP_INSTR : w_head.instr;
    assign bus.out_link  = link_addr(w_out_pc);
    assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : directed plan followed by random traffic, queue-model scoreboard
// Rev 1.0
// ============================================================================
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] C_RPC = 32'h0000_3000;

    logic clk = 1'b0;
    logic reset;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH     (DEPTH),
        .RESET_PC  (C_RPC),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    bit armed    = 1'b0;

    // Reference model: ordered list of what decode should see
    fetch_entry_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compare outputs against the model, then advance the model
    always @(negedge clk) begin
        logic [31:0] e_pc, e_instr;
        bit accept;
        int sz;
        sz = exp_q.size();
        if (armed) begin
            e_pc    = (sz != 0) ? exp_q[0].pc    : C_RPC;
            e_instr = (sz != 0) ? exp_q[0].instr : 32'h0;
            chk("out_valid", 32'(bus.out_valid), 32'(sz != 0));
            chk("in_ready",  32'(bus.in_ready),  32'(sz != DEPTH));
            chk("count",     32'(bus.count),     32'(sz));
            chk("out_pc",    bus.out_pc,    e_pc);
            chk("out_instr", bus.out_instr, e_instr);
            chk("out_link",  bus.out_link,  e_pc + 32'd8);
            if (sz != DEPTH)
                chk("ptr_diff", 32'(2'(dut.r_wr_ptr - dut.r_rd_ptr)), 32'(sz));
        end
        if (reset) begin
            exp_q.delete();
            armed = 1'b1;
        end else if (armed) begin
            accept = bus.in_valid && (sz < DEPTH) && !bus.flush;
            if (sz != 0 && bus.out_ready) begin
                void'(exp_q.pop_front());
                n_pops++;
            end
            if (bus.flush) exp_q.delete();
            else if (accept) exp_q.push_back('{pc: bus.in_pc, instr: bus.in_instr});
        end
    end

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0013;
    endfunction

    task automatic drive(input bit v, input logic [31:0] pc, input bit ordy,
                         input bit fl, input bit rst);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = mk_instr(pc);
        bus.out_ready = ordy;
        bus.flush     = fl;
        reset         = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0;
        bus.out_ready = 1'b0; bus.flush = 1'b0; reset = 1'b1;

        // Reset held with in_valid asserted
        drive(1, 32'h3000, 0, 0, 1);
        drive(1, 32'h3000, 0, 0, 1);

        // Fill, then a fifth offer that must be refused
        for (int i = 0; i < 5; i++) drive(1, 32'h3000 + 32'(4 * i), 0, 0, 0);

        // Drain in order
        for (int i = 0; i < 4; i++) drive(0, 32'h0, 1, 0, 0);
        drive(0, 32'h0, 0, 0, 0);

        // Streaming across pointer wrap
        for (int i = 0; i < 10; i++) drive(1, 32'h3000 + 32'(4 * i), 1, 0, 0);
        drive(0, 32'h0, 1, 0, 0);

        // Flush with same-cycle push and pop
        for (int i = 0; i < 3; i++) drive(1, 32'h3100 + 32'(4 * i), 0, 0, 0);
        drive(1, 32'h3020, 1, 1, 0);
        drive(1, 32'h4000, 0, 0, 0);
        drive(0, 32'h0, 0, 0, 0);
        drive(0, 32'h0, 1, 0, 0);

        // Reset mid-operation together with flush and push
        drive(1, 32'h5000, 0, 0, 0);
        drive(1, 32'h5004, 0, 0, 0);
        drive(1, 32'h5008, 1, 1, 1);
        drive(0, 32'h0, 1, 0, 0);
        drive(0, 32'h0, 1, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) < 70),
                  $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 99) < 55),
                  ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 199) < 1));
        end

        // Drain and check nothing lingers
        for (int i = 0; i < DEPTH + 2; i++) drive(0, 32'h0, 1, 0, 0);
        @(negedge clk);
        #1;
        n_checks++;
        if (n_pops > 100) n_pass++;
        else $display("FAIL pop_activity: got %0d pops required > 100", n_pops);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
